// File: rtl/gb_cart_bus_if.sv
// Game Boy cartridge-bus slave: synchronises /RD, /WR, /CS, address and pad data,
// runs read/write transactions to a memory backend and drives the data pads.
// Optional read-ack timeout: define GB_BUS_TIMEOUT_EN.
module gb_cart_bus_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] gb_addr,
  input  logic                  gb_rd_n,
  input  logic                  gb_wr_n,
  input  logic                  gb_cs_n,
  input  logic [DATA_WIDTH-1:0] pad_rx,
  output logic [DATA_WIDTH-1:0] pad_tx,
  output logic [DATA_WIDTH-1:0] pad_oe,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ram_sel,
  output logic                  mem_wr_stb,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy
`ifdef GB_BUS_TIMEOUT_EN
  ,
  output logic                  timeout_stb
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_DRIVE = 2'd2;
  localparam logic [1:0] WR_WAIT  = 2'd3;

  // Synchroniser chains; address and data share the strobe depth so they stay aligned.
  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, cs_sync_q;
  logic [ADDR_WIDTH-1:0]  addr_sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]  rx_sync_q   [SYNC_STAGES];
  logic                   rd_d1_q, wr_d1_q;
  logic [DATA_WIDTH-1:0]  rx_d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      cs_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= '0;
        rx_sync_q[i]   <= '0;
      end
      rd_d1_q <= 1'b1;
      wr_d1_q <= 1'b1;
      rx_d1_q <= '0;
    end else begin
      rd_sync_q      <= {rd_sync_q[SYNC_STAGES-2:0], gb_rd_n};
      wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], gb_wr_n};
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], gb_cs_n};
      addr_sync_q[0] <= gb_addr;
      rx_sync_q[0]   <= pad_rx;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= addr_sync_q[i-1];
        rx_sync_q[i]   <= rx_sync_q[i-1];
      end
      rd_d1_q <= rd_sync_q[SYNC_STAGES-1];
      wr_d1_q <= wr_sync_q[SYNC_STAGES-1];
      rx_d1_q <= rx_sync_q[SYNC_STAGES-1];
    end
  end

  logic                  rd_s, wr_s, cs_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  rd_fall, rd_rise, wr_fall, wr_rise;

  assign rd_s    = rd_sync_q[SYNC_STAGES-1];
  assign wr_s    = wr_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign addr_s  = addr_sync_q[SYNC_STAGES-1];
  assign rd_fall = rd_d1_q & ~rd_s;
  assign rd_rise = ~rd_d1_q & rd_s;
  assign wr_fall = wr_d1_q & ~wr_s;
  assign wr_rise = ~wr_d1_q & wr_s;

  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sel_q, sel_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef GB_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tstb_q, tstb_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    oe_d    = oe_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    stb_d   = 1'b0;
    wdata_d = wdata_q;
`ifdef GB_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    tstb_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Write wins when both strobes fall together.
        if (wr_fall) begin
          addr_d  = addr_s;
          sel_d   = ~cs_s;
          state_d = WR_WAIT;
        end else if (rd_fall && wr_s) begin
          addr_d  = addr_s;
          sel_d   = ~cs_s;
          req_d   = 1'b1;
          state_d = RD_WAIT;
`ifdef GB_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        // A host that releases /RD first aborts; a same-cycle ack is dropped.
        if (rd_rise) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (mem_rd_ack) begin
          tx_d    = mem_rd_data;
          req_d   = 1'b0;
          oe_d    = 1'b1;
          state_d = RD_DRIVE;
        end
`ifdef GB_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tx_d    = '1;
          req_d   = 1'b0;
          oe_d    = 1'b1;
          tstb_d  = 1'b1;
          state_d = RD_DRIVE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      RD_DRIVE: begin
        if (rd_rise) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (wr_rise) begin
          wdata_d = rx_d1_q;
          stb_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
      tx_q    <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      stb_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      oe_q    <= oe_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef GB_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tstb_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tstb_q <= tstb_d;
    end
  end
  assign timeout_stb = tstb_q;
`endif

  assign pad_tx      = tx_q;
  assign pad_oe      = {DATA_WIDTH{oe_q}};
  assign mem_rd_req  = req_q;
  assign mem_addr    = addr_q;
  assign mem_ram_sel = sel_q;
  assign mem_wr_stb  = stb_q;
  assign mem_wr_data = wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gb_cart_bus_if.sv
// Directed bench for gb_cart_bus_if: read, write, abort, simultaneous strobes,
// mid-transaction reset and (with GB_BUS_TIMEOUT_EN) the read timeout.
module tb_gb_cart_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gb_addr;
  logic        gb_rd_n, gb_wr_n, gb_cs_n;
  logic [7:0]  pad_rx, pad_tx, pad_oe;
  logic        mem_rd_req, mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic [15:0] mem_addr;
  logic        mem_ram_sel, mem_wr_stb;
  logic [7:0]  mem_wr_data;
  logic        busy;
`ifdef GB_BUS_TIMEOUT_EN
  logic        timeout_stb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gb_cart_bus_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gb_addr     (gb_addr),
    .gb_rd_n     (gb_rd_n),
    .gb_wr_n     (gb_wr_n),
    .gb_cs_n     (gb_cs_n),
    .pad_rx      (pad_rx),
    .pad_tx      (pad_tx),
    .pad_oe      (pad_oe),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .mem_ram_sel (mem_ram_sel),
    .mem_wr_stb  (mem_wr_stb),
    .mem_wr_data (mem_wr_data),
    .busy        (busy)
`ifdef GB_BUS_TIMEOUT_EN
    ,
    .timeout_stb (timeout_stb)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int stb_cnt, oe_seen, req_seen, first_to;
  logic [7:0] got_data;

  initial begin
    rst_n = 1'b0;
    gb_addr = 16'h0000; gb_rd_n = 1'b1; gb_wr_n = 1'b1; gb_cs_n = 1'b1;
    pad_rx = 8'h00; mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
    tick(3);
    check("rst_oe", pad_oe, 8'h00);
    check("rst_tx", pad_tx, 8'h00);
    check("rst_req", mem_rd_req, 0);
    check("rst_stb", mem_wr_stb, 0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);

    // Read 0x0150, backend acks 3 clk after request with 0x3E
    gb_addr = 16'h0150; gb_rd_n = 1'b0;
    tick(2);
    check("rd_req_early", mem_rd_req, 0);
    tick(1);
    check("rd_req_lat", mem_rd_req, 1);
    check("rd_addr", mem_addr, 16'h0150);
    check("rd_sel", mem_ram_sel, 0);
    check("rd_busy", busy, 1);
    check("rd_oe_wait", pad_oe, 8'h00);
    tick(2);
    mem_rd_ack = 1'b1; mem_rd_data = 8'h3E;
    tick(1);
    mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
    check("rd_oe_on", pad_oe, 8'hFF);
    check("rd_tx", pad_tx, 8'h3E);
    check("rd_req_drop", mem_rd_req, 0);
    tick(33);
    check("rd_oe_hold", pad_oe, 8'hFF);
    gb_rd_n = 1'b1;
    tick(2);
    check("rd_oe_pre_rel", pad_oe, 8'hFF);
    tick(1);
    check("rd_oe_off", pad_oe, 8'h00);
    check("rd_tx_keep", pad_tx, 8'h3E);
    check("rd_busy_end", busy, 0);
    tick(2);

    // RAM write 0x5A to 0xA000
    gb_cs_n = 1'b0; gb_addr = 16'hA000; pad_rx = 8'h5A; gb_wr_n = 1'b0;
    stb_cnt = 0; oe_seen = 0; req_seen = 0; got_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (mem_wr_stb) stb_cnt++;
      if (pad_oe != 8'h00) oe_seen++;
      if (mem_rd_req) req_seen++;
    end
    check("wr_busy", busy, 1);
    check("wr_addr", mem_addr, 16'hA000);
    check("wr_sel", mem_ram_sel, 1);
    gb_wr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (mem_wr_stb) begin stb_cnt++; got_data = mem_wr_data; end
      if (pad_oe != 8'h00) oe_seen++;
    end
    check("wr_stb_count", stb_cnt, 1);
    check("wr_data", got_data, 8'h5A);
    check("wr_oe_never", oe_seen, 0);
    check("wr_no_req", req_seen, 0);
    check("wr_busy_end", busy, 0);
    gb_cs_n = 1'b1;
    tick(2);

    // Abort: /RD released before any ack
    gb_addr = 16'h1234; gb_rd_n = 1'b0;
    tick(3);
    check("ab_req", mem_rd_req, 1);
    gb_rd_n = 1'b1;
    oe_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (pad_oe != 8'h00) oe_seen++;
    end
    check("ab_req_drop", mem_rd_req, 0);
    check("ab_busy", busy, 0);
    mem_rd_ack = 1'b1; mem_rd_data = 8'h99;
    tick(1);
    mem_rd_ack = 1'b0;
    tick(2);
    if (pad_oe != 8'h00) oe_seen++;
    check("ab_oe_never", oe_seen, 0);
    check("ab_late_ack", busy, 0);

    // Simultaneous /RD and /WR fall: write path
    gb_addr = 16'h4000; pad_rx = 8'h77; gb_rd_n = 1'b0; gb_wr_n = 1'b0;
    stb_cnt = 0; req_seen = 0; got_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (mem_rd_req) req_seen++;
    end
    check("sim_busy", busy, 1);
    gb_rd_n = 1'b1; gb_wr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (mem_rd_req) req_seen++;
      if (mem_wr_stb) begin stb_cnt++; got_data = mem_wr_data; end
    end
    check("sim_no_req", req_seen, 0);
    check("sim_stb_count", stb_cnt, 1);
    check("sim_data", got_data, 8'h77);
    check("sim_addr", mem_addr, 16'h4000);
    check("sim_sel", mem_ram_sel, 0);
    tick(2);

    // Reset while in RD_DRIVE
    gb_addr = 16'h0200; gb_rd_n = 1'b0;
    tick(3);
    mem_rd_ack = 1'b1; mem_rd_data = 8'h81;
    tick(1);
    mem_rd_ack = 1'b0;
    check("rr_oe_on", pad_oe, 8'hFF);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_oe_async", pad_oe, 8'h00);
    check("rr_tx", pad_tx, 8'h00);
    check("rr_addr", mem_addr, 16'h0000);
    check("rr_busy", busy, 0);
    check("rr_req", mem_rd_req, 0);
    gb_rd_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    gb_addr = 16'h0300; gb_rd_n = 1'b0;
    tick(3);
    check("rr2_req", mem_rd_req, 1);
    check("rr2_addr", mem_addr, 16'h0300);
    mem_rd_ack = 1'b1; mem_rd_data = 8'hC3;
    tick(1);
    mem_rd_ack = 1'b0;
    check("rr2_oe", pad_oe, 8'hFF);
    check("rr2_tx", pad_tx, 8'hC3);
    gb_rd_n = 1'b1;
    tick(3);
    check("rr2_oe_off", pad_oe, 8'h00);
    check("rr2_busy", busy, 0);

`ifdef GB_BUS_TIMEOUT_EN
    // No ack: timeout after 32 cycles in RD_WAIT
    tick(2);
    gb_addr = 16'h0100; gb_rd_n = 1'b0;
    tick(3);
    check("to_req", mem_rd_req, 1);
    first_to = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (timeout_stb && first_to == 0) first_to = k;
    end
    check("to_cycle", first_to, 32);
    check("to_tx", pad_tx, 8'hFF);
    check("to_oe", pad_oe, 8'hFF);
    check("to_req_drop", mem_rd_req, 0);
    gb_rd_n = 1'b1;
    tick(3);
    check("to_oe_off", pad_oe, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
